// File: rtl/imem_pkg.sv
// Shared constants and state type for the input memory block.
// Used by the memory, its writer and the read-out engine.
package imem_pkg;

    localparam int WIDTH  = 9;
    localparam int AW     = 6;
    localparam int NWORDS = 60;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imem_reader_if.sv
// Memory read-port and output-stream bundles for imem_reader.
// The engine is master on both; memory and consumer are slaves.
interface imem_mem_if
    import imem_pkg::*;
#(
    parameter int DW = WIDTH,
    parameter int A  = AW
);
    logic [A-1:0]  oaddr;
    logic          rd;
    logic [DW-1:0] odata;

    modport master (output oaddr, output rd, input odata);
    modport slave  (input oaddr, input rd, output odata);
endinterface

interface imem_stream_if
    import imem_pkg::*;
#(
    parameter int DW = WIDTH
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data, output out_valid,
        output out_last, input out_ready
    );
    modport slave (
        input out_data, input out_valid,
        input out_last, output out_ready
    );
endinterface

// File: rtl/imem_reader_fifo2.sv
// Two-entry synchronous FIFO; head is visible combinationally.
// Simultaneous push and pop are both performed.
module fifo2 #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] ent [2];
    logic         wp;
    logic         rp;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = ent[rp];

    // storage, pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                ent[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/imem_reader.sv
// Sequential read-out of NW memory words onto a valid/ready stream.
// Credit logic keeps buffered plus in-flight words within two.
module imem_reader
    import imem_pkg::*;
#(
    parameter int NW = NWORDS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    imem_mem_if.master   mem,
    imem_stream_if.master strm
);

    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LIMIT = IW'(NW);
    localparam logic [IW-1:0] LAST  = IW'(NW - 1);

    state_t state;
    state_t next_state;

    logic [IW-1:0]    issued;
    logic [IW-1:0]    index;
    logic             inflight;
    logic             rd_int;
    logic             pop;
    logic             last_pop;
    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [2:0]       credit;

    assign pop      = strm.out_valid & strm.out_ready;
    assign last_pop = pop && (index == LAST);
    assign credit   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    assign strm.out_valid = (count != 2'd0);
    assign strm.out_data  = head;
    assign strm.out_last  = strm.out_valid && (index == LAST);
    assign mem.rd         = rd_int;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (last_pop) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // outputs decoded from registered state and counters
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        rd_int   = (state == RUN) && (issued < LIMIT) &&
                   (credit < 3'd2);
        mem.oaddr = (state == RUN) ? issued[AW-1:0] : '0;
    end

    // issue and output index counters, restarted on accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued <= '0;
            index  <= '0;
        end else if (state == IDLE && start) begin
            issued <= '0;
            index  <= '0;
        end else begin
            if (rd_int) issued <= issued + 1'b1;
            if (pop)    index  <= index + 1'b1;
        end
    end

    // read data returns one cycle after the strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= rd_int;
    end

    fifo2 #(.W(WIDTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight),
        .din   (mem.odata),
        .pop   (pop),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_imem_reader.sv
// Randomised and directed bench for imem_reader (60-word and 1-word).
// Expected words come from the bench's own memory array, in order.
module tb_imem_reader;

    localparam int N = 60;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic ready = 1'b0;
    logic ready1 = 1'b0;
    logic busy, done, busy1, done1;

    logic [8:0] mem [64];

    int vectors = 0;
    int miscompares = 0;

    imem_mem_if    m0 ();
    imem_stream_if s0 ();
    imem_mem_if    m1 ();
    imem_stream_if s1 ();

    assign s0.out_ready = ready;
    assign s1.out_ready = ready1;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (m0.rd) m0.odata <= mem[m0.oaddr];
        if (m1.rd) m1.odata <= mem[m1.oaddr];
    end

    imem_reader #(.NW(N)) dut (
        .clock (clock), .reset (reset), .start (start),
        .busy (busy), .done (done), .mem (m0), .strm (s0)
    );

    imem_reader #(.NW(1)) dut1 (
        .clock (clock), .reset (reset), .start (start1),
        .busy (busy1), .done (done1), .mem (m1), .strm (s1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready=1, 1: toggling, 2: stalled 10 cycles,
    // 3: random ready, 4: ready=1 with stray start pulses
    task automatic read_out(input int mode);
        int k, rds, dcnt;
        logic stalled, held_last, seen;
        logic [8:0] held;
        k = 0; rds = 0; stalled = 0; seen = 0;
        held = '0; held_last = 0;
        for (int c = 0; c < 400; c++) begin
            start = (c == 0) || (mode == 4 && (c == 5 || c == 63));
            case (mode)
                1: ready = (c % 2 == 0);
                2: ready = (c >= 11);
                3: ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
            @(negedge clock);
            if (c == 1) begin
                check("c1_rd", m0.rd, 1);
                check("c1_oaddr", m0.oaddr, 0);
            end
            if (mode == 0 || mode == 4)
                check("busy", busy, (c >= 1 && !done));
            if (mode == 2 && c >= 3 && c <= 10)
                check("stall_rd", m0.rd, 0);
            check("occupancy_le2", (rds - k) <= 2, 1);
            if (m0.rd) begin
                check("oaddr_seq", m0.oaddr, rds);
                rds++;
            end
            if (mode == 2 && c == 10)
                check("stall_reads", rds, 2);
            if (stalled) begin
                check("hold_data", s0.out_data, held);
                check("hold_last", s0.out_last, held_last);
            end
            if (s0.out_valid && s0.out_ready) begin
                check("no_extra_word", k < N, 1);
                check("word", s0.out_data, mem[k % 64]);
                check("last", s0.out_last, (k == N - 1));
                if (mode == 0 || mode == 4)
                    check("word_cycle", c, 3 + k);
                if (mode == 2)
                    check("resume_cycle", c, 11 + k);
                if (mode == 0 && k == N - 1)
                    check("word59", s0.out_data, 178);
                k++;
            end
            stalled   = s0.out_valid && !s0.out_ready;
            held      = s0.out_data;
            held_last = s0.out_last;
            if (done) begin
                if (mode == 0 || mode == 4)
                    check("done_cycle", c, N + 3);
                check("done_words", k, N);
                check("done_busy", busy, 0);
                seen = 1;
            end
            @(posedge clock); #1;
            if (seen) break;
        end
        check("done_seen", seen, 1);
        check("rd_total", rds, N);
        start = 0;
        dcnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("idle_busy", busy, 0);
            check("idle_rd", m0.rd, 0);
            if (done) dcnt++;
            @(posedge clock); #1;
        end
        check("single_done", dcnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 9'((3 * i + 1) % 512);
        #12;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", m0.rd, 0);
        check("rst_oaddr", m0.oaddr, 0);
        check("rst_valid", s0.out_valid, 0);
        check("rst_data", s0.out_data, 0);
        check("rst_last", s0.out_last, 0);
        check("rst1_valid", s1.out_valid, 0);
        @(posedge clock); #1;
        reset = 0;

        read_out(0);
        read_out(1);
        read_out(2);
        read_out(4);

        // reset while word 20 sits at the buffer head
        start = 1; ready = 1;
        for (int c = 0; c < 23; c++) begin
            @(posedge clock); #1;
            start = 0;
        end
        ready = 0;
        @(negedge clock);
        check("w20_head", s0.out_data, mem[20]);
        check("w20_valid", s0.out_valid, 1);
        #2 reset = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd", m0.rd, 0);
        check("arst_oaddr", m0.oaddr, 0);
        check("arst_valid", s0.out_valid, 0);
        check("arst_data", s0.out_data, 0);
        check("arst_last", s0.out_last, 0);
        check("arst_done", done, 0);
        @(posedge clock); #1;
        reset = 0;
        ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("no_residual", s0.out_valid, 0);
            @(posedge clock); #1;
        end
        read_out(0);

        // random memory contents and random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = 9'($urandom);
            read_out(3);
        end

        // single-word instance
        mem[0] = 9'($urandom);
        start1 = 1; ready1 = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            case (c)
                1: begin
                    check("n1_rd", m1.rd, 1);
                    check("n1_oaddr", m1.oaddr, 0);
                end
                2: check("n1_rd_stop", m1.rd, 0);
                3: begin
                    check("n1_valid", s1.out_valid, 1);
                    check("n1_last", s1.out_last, 1);
                    check("n1_data", s1.out_data, mem[0]);
                end
                4: begin
                    check("n1_done", done1, 1);
                    check("n1_empty", s1.out_valid, 0);
                end
                default: check("n1_nodone", done1, 0);
            endcase
            if (c >= 2) check("n1_one_rd", m1.rd, 0);
            @(posedge clock); #1;
            start1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
